// File: rtl/mfp_adc_max10_sequencer_pkg.sv
// Shared constants, state encoding and mask helper for the MAX10 ADC sequencer.
package mfp_adc_max10_sequencer_pkg;

    localparam int N_CHANNELS = 17;
    localparam int DATA_W     = 12;
    localparam int CH_W       = 5;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CMD      = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_NEXT     = 2'd3
    } state_t;

    // Lowest set bit of a non-empty channel mask (0 when the mask is empty).
    function automatic logic [CH_W-1:0] first_set(input logic [N_CHANNELS-1:0] mask);
        logic [CH_W-1:0] ch;
        ch = '0;
        for (int i = N_CHANNELS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                ch = CH_W'(i);
            end
        end
        return ch;
    endfunction

endpackage

// File: rtl/mfp_adc_next_channel.sv
// Finds the lowest enabled channel strictly above the current one.
module mfp_adc_next_channel
    import mfp_adc_max10_sequencer_pkg::*;
(
    input  logic [N_CHANNELS-1:0] mask,
    input  logic [CH_W-1:0]       cur_channel,
    output logic [CH_W-1:0]       next_channel,
    output logic                  found
);

    // Scan high to low so the last hit is the lowest qualifying bit.
    always_comb begin
        next_channel = '0;
        found        = 1'b0;
        for (int i = N_CHANNELS - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur_channel))) begin
                next_channel = CH_W'(i);
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mfp_adc_max10_sequencer.sv
// Sweeps the enabled channels of a MAX10 ADC one command at a time and
// stores each returned sample in a per-channel result register.
//
// state    | meaning
// IDLE     | waiting for a single or continuous sweep request
// CMD      | command presented, held until the ADC accepts it
// WAIT_RSP | waiting for the response, bounded by TIMEOUT_CYCLES
// NEXT     | one cycle: pick next channel, or finish / restart the sweep
module mfp_adc_max10_sequencer
    import mfp_adc_max10_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023
)
(
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cfg_enable,
    input  logic                  cfg_single,
    input  logic [N_CHANNELS-1:0] cfg_mask,
    input  logic                  err_clear,
    output logic                  ADC_C_Valid,
    output logic [CH_W-1:0]       ADC_C_Channel,
    output logic                  ADC_C_SOP,
    output logic                  ADC_C_EOP,
    input  logic                  ADC_C_Ready,
    input  logic                  ADC_R_Valid,
    input  logic [CH_W-1:0]       ADC_R_Channel,
    input  logic [DATA_W-1:0]     ADC_R_Data,
    input  logic                  ADC_R_SOP,
    input  logic                  ADC_R_EOP,
    input  logic [CH_W-1:0]       rd_channel,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  busy,
    output logic                  sweep_done,
    output logic                  err_timeout,
    output logic                  err_channel
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t                state_q, state_d;
    logic [CH_W-1:0]       chan_q, chan_d;
    logic [N_CHANNELS-1:0] mask_q, mask_d;
    logic                  valid_q, valid_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic                  busy_q, busy_d;
    logic                  sweep_done_q, sweep_done_d;
    logic                  err_timeout_q, err_timeout_d;
    logic                  err_channel_q, err_channel_d;
    logic [DATA_W-1:0]     result_q [N_CHANNELS];
    logic [DATA_W-1:0]     result_d [N_CHANNELS];

    logic [TMR_W-1:0]      timer_inc;
    logic                  set_timeout;
    logic                  set_chan_err;
    logic [CH_W-1:0]       nxt_chan;
    logic                  nxt_found;

    // Response framing is single-beat, so the ADC's SOP/EOP carry nothing useful.
    logic unused_rsp_framing;
    assign unused_rsp_framing = ADC_R_SOP ^ ADC_R_EOP;

    mfp_adc_next_channel u_next_channel (
        .mask         (mask_q),
        .cur_channel  (chan_q),
        .next_channel (nxt_chan),
        .found        (nxt_found)
    );

    assign timer_inc = timer_q + TMR_W'(1);

    // Next-state and datapath decisions for the sweep sequencer.
    always_comb begin
        state_d       = state_q;
        chan_d        = chan_q;
        mask_d        = mask_q;
        valid_d       = valid_q;
        timer_d       = timer_q;
        sweep_done_d  = 1'b0;
        err_timeout_d = err_timeout_q;
        err_channel_d = err_channel_q;
        result_d      = result_q;
        set_timeout   = 1'b0;
        set_chan_err  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if ((cfg_enable || cfg_single) && (cfg_mask != '0)) begin
                    mask_d  = cfg_mask;
                    chan_d  = first_set(cfg_mask);
                    valid_d = 1'b1;
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (ADC_C_Ready) begin
                    valid_d = 1'b0;
                    timer_d = '0;
                    state_d = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                if (ADC_R_Valid) begin
                    if (ADC_R_Channel == chan_q) begin
                        result_d[chan_q] = ADC_R_Data;
                    end else begin
                        set_chan_err = 1'b1;
                    end
                    state_d = ST_NEXT;
                end else if (timer_inc == TMR_W'(TIMEOUT_CYCLES)) begin
                    set_timeout = 1'b1;
                    state_d     = ST_NEXT;
                end else begin
                    timer_d = timer_inc;
                end
            end
            ST_NEXT: begin
                if (nxt_found) begin
                    chan_d  = nxt_chan;
                    valid_d = 1'b1;
                    state_d = ST_CMD;
                end else begin
                    sweep_done_d = 1'b1;
                    if (cfg_enable && (cfg_mask != '0)) begin
                        mask_d  = cfg_mask;
                        chan_d  = first_set(cfg_mask);
                        valid_d = 1'b1;
                        state_d = ST_CMD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        // A fresh error outranks a clear arriving in the same cycle.
        if (err_clear) begin
            err_timeout_d = 1'b0;
            err_channel_d = 1'b0;
        end
        if (set_timeout) begin
            err_timeout_d = 1'b1;
        end
        if (set_chan_err) begin
            err_channel_d = 1'b1;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State, registered outputs and result storage.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            chan_q        <= '0;
            mask_q        <= '0;
            valid_q       <= 1'b0;
            timer_q       <= '0;
            busy_q        <= 1'b0;
            sweep_done_q  <= 1'b0;
            err_timeout_q <= 1'b0;
            err_channel_q <= 1'b0;
            for (int i = 0; i < N_CHANNELS; i++) begin
                result_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            chan_q        <= chan_d;
            mask_q        <= mask_d;
            valid_q       <= valid_d;
            timer_q       <= timer_d;
            busy_q        <= busy_d;
            sweep_done_q  <= sweep_done_d;
            err_timeout_q <= err_timeout_d;
            err_channel_q <= err_channel_d;
            result_q      <= result_d;
        end
    end

    assign ADC_C_Valid   = valid_q;
    assign ADC_C_Channel = chan_q;
    assign ADC_C_SOP     = 1'b1;
    assign ADC_C_EOP     = 1'b1;
    assign busy          = busy_q;
    assign sweep_done    = sweep_done_q;
    assign err_timeout   = err_timeout_q;
    assign err_channel   = err_channel_q;
    assign rd_data       = (rd_channel < CH_W'(N_CHANNELS)) ? result_q[rd_channel] : '0;

endmodule

// File: tb/tb_mfp_adc_max10_sequencer.sv
// Directed bench for the MAX10 ADC sequencer with a hand-driven ADC model.
module tb_mfp_adc_max10_sequencer;

    logic        clk;
    logic        resetn;
    logic        cfg_enable;
    logic        cfg_single;
    logic [16:0] cfg_mask;
    logic        err_clear;
    logic        ADC_C_Valid;
    logic [4:0]  ADC_C_Channel;
    logic        ADC_C_SOP;
    logic        ADC_C_EOP;
    logic        ADC_C_Ready;
    logic        ADC_R_Valid;
    logic [4:0]  ADC_R_Channel;
    logic [11:0] ADC_R_Data;
    logic        ADC_R_SOP;
    logic        ADC_R_EOP;
    logic [4:0]  rd_channel;
    logic [11:0] rd_data;
    logic        busy;
    logic        sweep_done;
    logic        err_timeout;
    logic        err_channel;

    int n_checks = 0;
    int n_err    = 0;
    int n_acc    = 0;
    int n_done   = 0;

    mfp_adc_max10_sequencer #(.TIMEOUT_CYCLES(15)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .cfg_enable    (cfg_enable),
        .cfg_single    (cfg_single),
        .cfg_mask      (cfg_mask),
        .err_clear     (err_clear),
        .ADC_C_Valid   (ADC_C_Valid),
        .ADC_C_Channel (ADC_C_Channel),
        .ADC_C_SOP     (ADC_C_SOP),
        .ADC_C_EOP     (ADC_C_EOP),
        .ADC_C_Ready   (ADC_C_Ready),
        .ADC_R_Valid   (ADC_R_Valid),
        .ADC_R_Channel (ADC_R_Channel),
        .ADC_R_Data    (ADC_R_Data),
        .ADC_R_SOP     (ADC_R_SOP),
        .ADC_R_EOP     (ADC_R_EOP),
        .rd_channel    (rd_channel),
        .rd_data       (rd_data),
        .busy          (busy),
        .sweep_done    (sweep_done),
        .err_timeout   (err_timeout),
        .err_channel   (err_channel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count accepted commands and sweep_done cycles.
    always @(posedge clk) begin
        if (ADC_C_Valid === 1'b1 && ADC_C_Ready === 1'b1) n_acc++;
        if (sweep_done === 1'b1) n_done++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic rd_chk(input int ch, input logic [11:0] exp, input string tag);
        rd_channel = 5'(ch);
        #1;
        chk($sformatf("%s_rd%0d", tag, ch), 32'(rd_data), 32'(exp));
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    // mode 0: matching response, 1: response on rsp_ch, 2: no response
    task automatic serve(input int exp_ch, input int rdy_dly, input int mode, input int rsp_ch,
                         input logic [11:0] data, input bit clr, input string tag);
        for (int i = 0; i < 40 && ADC_C_Valid !== 1'b1; i++) tick();
        chk({tag, "_valid"}, 32'(ADC_C_Valid), 32'd1);
        chk({tag, "_chan"}, 32'(ADC_C_Channel), 32'(exp_ch));
        for (int i = 1; i <= rdy_dly; i++) begin
            tick();
            chk({tag, "_hold_valid"}, 32'(ADC_C_Valid), 32'd1);
            chk({tag, "_hold_chan"}, 32'(ADC_C_Channel), 32'(exp_ch));
        end
        ADC_C_Ready = 1'b1;
        tick();
        ADC_C_Ready = 1'b0;
        chk({tag, "_drop"}, 32'(ADC_C_Valid), 32'd0);
        if (mode == 2) return;
        tick();
        ADC_R_Valid   = 1'b1;
        ADC_R_Channel = 5'((mode == 1) ? rsp_ch : exp_ch);
        ADC_R_Data    = data;
        err_clear     = clr;
        tick();
        ADC_R_Valid = 1'b0;
        err_clear   = 1'b0;
    endtask

    typedef struct {
        logic [16:0] mask;
        logic [11:0] base;
        int          rdy_dly;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int acc0;
        int done0;

        vecs[0] = '{17'h00001, 12'h100, 0};
        vecs[1] = '{17'h10000, 12'h200, 1};
        vecs[2] = '{17'h0A50C, 12'h300, 2};
        vecs[3] = '{17'h1FFFF, 12'h400, 0};
        vecs[4] = '{17'h00040, 12'h600, 10};

        resetn = 1'b0; cfg_enable = 1'b0; cfg_single = 1'b0; cfg_mask = '0;
        err_clear = 1'b0; ADC_C_Ready = 1'b0; ADC_R_Valid = 1'b0;
        ADC_R_Channel = '0; ADC_R_Data = '0; ADC_R_SOP = 1'b0; ADC_R_EOP = 1'b0;
        rd_channel = '0;

        // Reset state
        tick();
        tick();
        chk("rst_valid", 32'(ADC_C_Valid), 32'd0);
        chk("rst_chan", 32'(ADC_C_Channel), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(sweep_done), 32'd0);
        chk("rst_errs", 32'({err_timeout, err_channel}), 32'd0);
        chk("rst_sop_eop", 32'({ADC_C_SOP, ADC_C_EOP}), 32'd3);
        rd_chk(5, 12'h000, "rst");
        resetn = 1'b1;
        tick();

        // Table-driven single sweeps: ADC returns base + channel
        for (int r = 0; r < 5; r++) begin
            do_reset();
            acc0 = n_acc;
            cfg_mask   = vecs[r].mask;
            cfg_single = 1'b1;
            tick();
            cfg_single = 1'b0;
            chk($sformatf("v%0d_latency", r), 32'(ADC_C_Valid), 32'd1);
            chk($sformatf("v%0d_busy", r), 32'(busy), 32'd1);
            for (int c = 0; c < 17; c++) begin
                if (vecs[r].mask[c]) begin
                    serve(c, vecs[r].rdy_dly, 0, 0, 12'(vecs[r].base + 12'(c)), 1'b0,
                          $sformatf("v%0d_c%0d", r, c));
                end
            end
            tick();
            chk($sformatf("v%0d_done", r), 32'(sweep_done), 32'd1);
            chk($sformatf("v%0d_idle", r), 32'(busy), 32'd0);
            tick();
            chk($sformatf("v%0d_done_pulse", r), 32'(sweep_done), 32'd0);
            chk($sformatf("v%0d_ncmd", r), 32'(n_acc - acc0), 32'($countones(vecs[r].mask)));
            for (int c = 0; c < 17; c++) begin
                rd_chk(c, vecs[r].mask[c] ? 12'(vecs[r].base + 12'(c)) : 12'h000, $sformatf("v%0d", r));
            end
            rd_chk(17, 12'h000, $sformatf("v%0d", r));
            rd_chk(31, 12'h000, $sformatf("v%0d", r));
        end

        // Two-channel sweep with specific data
        do_reset();
        done0 = n_done;
        cfg_mask = 17'h00005;
        cfg_single = 1'b1;
        tick();
        cfg_single = 1'b0;
        serve(0, 0, 0, 0, 12'h123, 1'b0, "pair_c0");
        serve(2, 0, 0, 0, 12'hABC, 1'b0, "pair_c2");
        tick();
        tick();
        tick();
        chk("pair_ndone", 32'(n_done - done0), 32'd1);
        chk("pair_idle", 32'(busy), 32'd0);
        rd_chk(0, 12'h123, "pair");
        rd_chk(2, 12'hABC, "pair");

        // Timeout on ch4, sweep continues to ch5
        do_reset();
        cfg_mask = 17'h00010;
        cfg_single = 1'b1;
        tick();
        cfg_single = 1'b0;
        serve(4, 0, 0, 0, 12'h444, 1'b0, "to_pre");
        tick();
        cfg_mask = 17'h00030;
        cfg_single = 1'b1;
        tick();
        cfg_single = 1'b0;
        serve(4, 0, 2, 0, 12'h000, 1'b0, "to_c4");
        for (int i = 0; i < 14; i++) tick();
        chk("to_not_yet", 32'(err_timeout), 32'd0);
        chk("to_still_busy", 32'(busy), 32'd1);
        tick();
        chk("to_flag", 32'(err_timeout), 32'd1);
        serve(5, 0, 0, 0, 12'h555, 1'b0, "to_c5");
        tick();
        chk("to_done", 32'(sweep_done), 32'd1);
        rd_chk(4, 12'h444, "to");
        rd_chk(5, 12'h555, "to");
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("to_clear", 32'(err_timeout), 32'd0);

        // Wrong response channel, clear in the same cycle loses
        do_reset();
        cfg_mask = 17'h00088;
        cfg_single = 1'b1;
        tick();
        cfg_single = 1'b0;
        serve(3, 0, 0, 0, 12'h333, 1'b0, "ch_pre3");
        serve(7, 0, 0, 0, 12'h777, 1'b0, "ch_pre7");
        tick();
        tick();
        chk("ch_no_err", 32'(err_channel), 32'd0);
        cfg_mask = 17'h00008;
        cfg_single = 1'b1;
        tick();
        cfg_single = 1'b0;
        serve(3, 0, 1, 7, 12'hEEE, 1'b1, "ch_bad");
        tick();
        chk("ch_err", 32'(err_channel), 32'd1);
        chk("ch_done", 32'(sweep_done), 32'd1);
        rd_chk(3, 12'h333, "ch");
        rd_chk(7, 12'h777, "ch");

        // Reset while waiting for a response
        cfg_mask = 17'h00003;
        cfg_single = 1'b1;
        tick();
        cfg_single = 1'b0;
        serve(0, 0, 0, 0, 12'h055, 1'b0, "rs_c0");
        serve(1, 0, 2, 0, 12'h000, 1'b0, "rs_c1");
        tick();
        resetn = 1'b0;
        #1;
        chk("rs_valid", 32'(ADC_C_Valid), 32'd0);
        chk("rs_chan", 32'(ADC_C_Channel), 32'd0);
        chk("rs_busy", 32'(busy), 32'd0);
        chk("rs_errs", 32'({err_timeout, err_channel}), 32'd0);
        chk("rs_sop_eop", 32'({ADC_C_SOP, ADC_C_EOP}), 32'd3);
        rd_chk(0, 12'h000, "rs");
        rd_chk(3, 12'h000, "rs");
        tick();
        tick();
        resetn = 1'b1;
        acc0 = n_acc;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rs_quiet", 32'(ADC_C_Valid), 32'd0);
        end
        chk("rs_no_cmd", 32'(n_acc - acc0), 32'd0);
        cfg_mask = 17'h00000;
        cfg_single = 1'b1;
        tick();
        cfg_single = 1'b0;
        chk("zero_mask_busy", 32'(busy), 32'd0);
        chk("zero_mask_valid", 32'(ADC_C_Valid), 32'd0);
        tick();
        chk("zero_mask_busy2", 32'(busy), 32'd0);

        // Response while idle is ignored
        ADC_R_Valid = 1'b1;
        ADC_R_Channel = 5'd9;
        ADC_R_Data = 12'hFFF;
        tick();
        ADC_R_Valid = 1'b0;
        tick();
        chk("idle_rsp_err", 32'(err_channel), 32'd0);
        rd_chk(9, 12'h000, "idle_rsp");

        // Continuous sweeps, mask change and enable drop mid-sweep
        do_reset();
        done0 = n_done;
        cfg_mask = 17'h10001;
        cfg_enable = 1'b1;
        tick();
        chk("cont_latency", 32'(ADC_C_Valid), 32'd1);
        for (int s = 0; s < 3; s++) begin
            serve(0, 0, 0, 0, 12'(12'h0A0 + 12'(s)), 1'b0, $sformatf("cont_s%0d_c0", s));
            if (s == 2) cfg_mask = 17'h00002;
            serve(16, 0, 0, 0, 12'(12'h1B0 + 12'(s)), 1'b0, $sformatf("cont_s%0d_c16", s));
        end
        tick();
        chk("cont_done3", 32'(sweep_done), 32'd1);
        cfg_enable = 1'b0;
        serve(1, 0, 0, 0, 12'h0C1, 1'b0, "cont_s3_c1");
        tick();
        chk("cont_done4", 32'(sweep_done), 32'd1);
        chk("cont_idle", 32'(busy), 32'd0);
        tick();
        tick();
        chk("cont_ndone", 32'(n_done - done0), 32'd4);
        chk("cont_stopped", 32'(ADC_C_Valid), 32'd0);
        rd_chk(0, 12'h0A2, "cont");
        rd_chk(16, 12'h1B2, "cont");
        rd_chk(1, 12'h0C1, "cont");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
